// File: rtl/axis_tlp_rr_arbiter.sv
// Purpose: packet-granular round-robin arbiter muxing NUM_SRC TLP streams onto one 512-bit AXI4-Stream master.
// Latency: 1 cycle IDLE->BUSY arbitration, then 1 cycle from source acceptance to M_AXIS presentation.
// Backpressure: the granted source sees TREADY only while the output register is empty or draining this cycle.
//
// Ports:
//   ACLK, ARESETN          clock, synchronous active-low reset
//   S_AXIS_*               NUM_SRC packed source streams (source i in slice i)
//   M_AXIS_*               registered master stream, TUSER taken from the granted beat
//   GRANT / GRANT_VALID    current or last granted source index / high while a packet is locked
module axis_tlp_rr_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int AXI_TUSER_L = 161,
    localparam int GW         = $clog2(NUM_SRC)
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,

    input  logic [NUM_SRC*512-1:0]         S_AXIS_TDATA,
    input  logic [NUM_SRC*16-1:0]          S_AXIS_TKEEP,
    input  logic [NUM_SRC*AXI_TUSER_L-1:0] S_AXIS_TUSER,
    input  logic [NUM_SRC-1:0]             S_AXIS_TLAST,
    input  logic [NUM_SRC-1:0]             S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]             S_AXIS_TREADY,

    output logic [511:0]                   M_AXIS_TDATA,
    output logic [15:0]                    M_AXIS_TKEEP,
    output logic [AXI_TUSER_L-1:0]         M_AXIS_TUSER,
    output logic                           M_AXIS_TLAST,
    output logic                           M_AXIS_TVALID,
    input  logic                           M_AXIS_TREADY,

    output logic [GW-1:0]                  GRANT,
    output logic                           GRANT_VALID
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          last_grant;

    logic [511:0]           m_tdata_q;
    logic [15:0]            m_tkeep_q;
    logic [AXI_TUSER_L-1:0] m_tuser_q;
    logic                   m_tlast_q;
    logic                   m_tvalid_q;

    logic [511:0]           g_tdata;
    logic [15:0]            g_tkeep;
    logic [AXI_TUSER_L-1:0] g_tuser;
    logic                   g_tlast;
    logic                   g_tvalid;

    logic                   out_free;
    logic                   beat_acc;
    logic [GW-1:0]          rr_sel;
    logic                   rr_found;

    // Output register can take a beat if empty or being drained this very cycle.
    assign out_free = !m_tvalid_q || M_AXIS_TREADY;

    // Granted source's beat.
    always_comb begin
        g_tdata  = S_AXIS_TDATA[int'(grant_q)*512 +: 512];
        g_tkeep  = S_AXIS_TKEEP[int'(grant_q)*16 +: 16];
        g_tuser  = S_AXIS_TUSER[int'(grant_q)*AXI_TUSER_L +: AXI_TUSER_L];
        g_tlast  = S_AXIS_TLAST[grant_q];
        g_tvalid = S_AXIS_TVALID[grant_q];
    end

    // Only the locked source ever sees ready; everything is held off in IDLE.
    always_comb begin
        S_AXIS_TREADY = '0;
        if (state == BUSY) begin
            S_AXIS_TREADY[grant_q] = out_free;
        end
    end

    assign beat_acc = (state == BUSY) && g_tvalid && out_free;

    // Round-robin search starting just after the last winner. The modulo keeps
    // the search inside 0..NUM_SRC-1 when NUM_SRC is not a power of two.
    always_comb begin
        rr_sel   = last_grant;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!rr_found && S_AXIS_TVALID[(int'(last_grant) + k) % NUM_SRC]) begin
                rr_sel   = GW'((int'(last_grant) + k) % NUM_SRC);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state      <= IDLE;
            grant_q    <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant_q    <= rr_sel;
                        last_grant <= rr_sel;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant stays locked through source TVALID gaps until TLAST.
                    if (beat_acc && g_tlast) begin
                        state <= IDLE;
                    end
                end
            endcase

            // A load wins over a drain, so TLAST-accept plus drain keeps TVALID high.
            if (beat_acc) begin
                m_tdata_q  <= g_tdata;
                m_tkeep_q  <= g_tkeep;
                m_tuser_q  <= g_tuser;
                m_tlast_q  <= g_tlast;
                m_tvalid_q <= 1'b1;
            end else if (m_tvalid_q && M_AXIS_TREADY) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign M_AXIS_TDATA  = m_tdata_q;
    assign M_AXIS_TKEEP  = m_tkeep_q;
    assign M_AXIS_TUSER  = m_tuser_q;
    assign M_AXIS_TLAST  = m_tlast_q;
    assign M_AXIS_TVALID = m_tvalid_q;
    assign GRANT         = grant_q;
    assign GRANT_VALID   = (state == BUSY);

endmodule

// File: tb/tb_axis_tlp_rr_arbiter.sv
// Bench for axis_tlp_rr_arbiter: directed scenarios plus randomized traffic
// checked against a packet-level round-robin model and beat scoreboard.
module tb_axis_tlp_rr_arbiter;

    localparam int N  = 4;
    localparam int TU = 161;

    typedef struct packed {
        logic [511:0]  d;
        logic [15:0]   k;
        logic [TU-1:0] u;
        logic          l;
    } beat_t;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    logic [N*512-1:0] s_tdata;
    logic [N*16-1:0]  s_tkeep;
    logic [N*TU-1:0]  s_tuser;
    logic [N-1:0]     s_tlast, s_tvalid, s_tready;
    logic [511:0]     m_tdata;
    logic [15:0]      m_tkeep;
    logic [TU-1:0]    m_tuser;
    logic             m_tlast, m_tvalid, m_tready;
    logic [1:0]       grant;
    logic             gv;

    // NUM_SRC=3 instance
    logic [3*512-1:0] t3_tdata;
    logic [47:0]      t3_tkeep;
    logic [23:0]      t3_tuser;
    logic [2:0]       t3_tlast, t3_tvalid, t3_tready;
    logic [511:0]     t3_m_tdata;
    logic [15:0]      t3_m_tkeep;
    logic [7:0]       t3_m_tuser;
    logic             t3_m_tlast, t3_m_tvalid, t3_m_tready;
    logic [1:0]       t3_grant;
    logic             t3_gv;

    axis_tlp_rr_arbiter #(.NUM_SRC(N), .AXI_TUSER_L(TU)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TUSER(s_tuser),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TUSER(m_tuser),
        .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .GRANT(grant), .GRANT_VALID(gv)
    );

    axis_tlp_rr_arbiter #(.NUM_SRC(3), .AXI_TUSER_L(8)) dut3 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_TDATA(t3_tdata), .S_AXIS_TKEEP(t3_tkeep), .S_AXIS_TUSER(t3_tuser),
        .S_AXIS_TLAST(t3_tlast), .S_AXIS_TVALID(t3_tvalid), .S_AXIS_TREADY(t3_tready),
        .M_AXIS_TDATA(t3_m_tdata), .M_AXIS_TKEEP(t3_m_tkeep), .M_AXIS_TUSER(t3_m_tuser),
        .M_AXIS_TLAST(t3_m_tlast), .M_AXIS_TVALID(t3_m_tvalid), .M_AXIS_TREADY(t3_m_tready),
        .GRANT(t3_grant), .GRANT_VALID(t3_gv)
    );

    int    n_vec = 0;
    int    n_err = 0;
    beat_t srcq[N][$];
    int    drop_pct;
    int    stall_pct;
    bit    stall_pat[$];

    function automatic beat_t m_beat();
        beat_t b;
        b.d = m_tdata; b.k = m_tkeep; b.u = m_tuser; b.l = m_tlast;
        return b;
    endfunction

    function automatic beat_t mk_beat(input int src, input int seq, input bit last);
        beat_t        b;
        logic [191:0] u;
        for (int w = 0; w < 16; w++) b.d[w*32 +: 32] = $urandom;
        for (int w = 0; w < 6; w++) u[w*32 +: 32] = $urandom;
        b.d[7:0]  = 8'(src);
        b.d[15:8] = 8'(seq);
        b.k       = 16'($urandom);
        b.u       = u[TU-1:0];
        b.l       = last;
        return b;
    endfunction

    task automatic set_src(input int i, input beat_t b, input bit v);
        s_tdata[i*512 +: 512] = b.d;
        s_tkeep[i*16 +: 16]   = b.k;
        s_tuser[i*TU +: TU]   = b.u;
        s_tlast[i]            = b.l;
        s_tvalid[i]           = v;
    endtask

    task automatic do_reset();
        ARESETN   = 1'b0;
        s_tvalid  = '0;
        t3_tvalid = '0;
        m_tready  = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // Generates npk packets of random length for source s.
    task automatic gen_packets(input int s, input int npk, input int maxlen);
        int len;
        for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, maxlen);
            for (int j = 0; j < len; j++) srcq[s].push_back(mk_beat(s, p*16 + j, j == len-1));
        end
    endtask

    // Drives srcq through the DUT. Every source holding a packet start keeps
    // TVALID high, so each arbitration sees all sources with pending packets
    // and the output packet order is plain round-robin over non-empty queues.
    task automatic run_traffic(input int max_cyc);
        beat_t    expq[$];
        beat_t    b, snap;
        int       pos[N];
        int       lg, found;
        bit       mid[N];
        bit       prev_stall;
        bit       v;
        logic [N-1:0] exp_rdy;

        lg = N - 1;
        for (int i = 0; i < N; i++) begin pos[i] = 0; mid[i] = 1'b0; end
        do begin
            found = -1;
            for (int k = 1; k <= N; k++)
                if (found < 0 && pos[(lg+k)%N] < srcq[(lg+k)%N].size()) found = (lg+k)%N;
            if (found >= 0) begin
                do begin
                    expq.push_back(srcq[found][pos[found]]);
                    pos[found]++;
                end while (!srcq[found][pos[found]-1].l);
                lg = found;
            end
        end while (found >= 0);

        prev_stall = 1'b0;
        snap       = '0;
        for (int cyc = 0; cyc < max_cyc && expq.size() > 0; cyc++) begin
            @(negedge ACLK);
            if (prev_stall) begin
                n_vec++;
                if (m_beat() !== snap || m_tvalid !== 1'b1) begin
                    n_err++;
                    $display("FAIL hold: got %h/%b expected %h/1", m_beat(), m_tvalid, snap);
                end
            end
            for (int i = 0; i < N; i++) begin
                v = (srcq[i].size() > 0) && !(mid[i] && ($urandom_range(99) < drop_pct));
                set_src(i, (srcq[i].size() > 0) ? srcq[i][0] : beat_t'(0), v);
            end
            if (stall_pat.size() > 0) m_tready = stall_pat.pop_front();
            else                      m_tready = ($urandom_range(99) >= stall_pct);
            #1;
            exp_rdy = '0;
            if (gv) exp_rdy[grant] = !m_tvalid || m_tready;
            n_vec++;
            if (s_tready !== exp_rdy) begin
                n_err++;
                $display("FAIL s_tready: got %b expected %b", s_tready, exp_rdy);
            end
            if (m_tvalid && m_tready) begin
                n_vec++;
                b = expq.pop_front();
                if (m_beat() !== b) begin
                    n_err++;
                    $display("FAIL m_beat: got %h expected %h", m_beat(), b);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    mid[i] = !srcq[i][0].l;
                    void'(srcq[i].pop_front());
                end
            end
            prev_stall = m_tvalid && !m_tready;
            snap       = m_beat();
        end
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL traffic_timeout: got %0d beats outstanding expected 0", expq.size());
        end
        @(negedge ACLK);
        s_tvalid = '0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) srcq[i].delete();
    endtask

    task automatic test_reset();
        ARESETN  = 1'b0;
        s_tvalid = '1;
        m_tready = 1'b1;
        repeat (2) @(negedge ACLK);
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
        n_vec++; if ({m_tdata, m_tkeep, m_tuser} !== '0) begin n_err++; $display("FAIL rst_data: got nonzero expected 0"); end
        n_vec++; if (s_tready !== 4'b0) begin n_err++; $display("FAIL rst_s_tready: got %b expected 0000", s_tready); end
        n_vec++; if (grant !== 2'd0 || gv !== 1'b0) begin n_err++; $display("FAIL rst_grant: got %0d/%b expected 0/0", grant, gv); end
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_vec++; if (grant !== 2'd0 || gv !== 1'b1) begin n_err++; $display("FAIL first_grant: got %0d/%b expected 0/1", grant, gv); end
        s_tvalid = '0;
        do_reset();
    endtask

    task automatic test_single_source();
        beat_t b[3];
        do_reset();
        for (int j = 0; j < 3; j++) b[j] = mk_beat(2, j, j == 2);
        set_src(2, b[0], 1'b1);
        @(negedge ACLK);
        n_vec++; if (grant !== 2'd2 || gv !== 1'b1) begin n_err++; $display("FAIL ss_grant: got %0d/%b expected 2/1", grant, gv); end
        n_vec++; if (s_tready !== 4'b0100) begin n_err++; $display("FAIL ss_ready: got %b expected 0100", s_tready); end
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL ss_early: got %b expected 0", m_tvalid); end
        for (int j = 0; j < 3; j++) begin
            @(negedge ACLK);
            n_vec++;
            if (m_beat() !== b[j] || m_tvalid !== 1'b1) begin
                n_err++;
                $display("FAIL ss_beat%0d: got %h expected %h", j, m_beat(), b[j]);
            end
            if (j < 2) set_src(2, b[j+1], 1'b1);
            else       set_src(2, b[j], 1'b0);
        end
        #1;
        n_vec++; if (gv !== 1'b0 || s_tready !== 4'b0) begin n_err++; $display("FAIL ss_idle: got %b/%b expected 0/0000", gv, s_tready); end
        @(negedge ACLK);
        n_vec++; if (m_tvalid !== 1'b0 || grant !== 2'd2) begin n_err++; $display("FAIL ss_drain: got %b/%0d expected 0/2", m_tvalid, grant); end
    endtask

    task automatic test_round_robin();
        int gq[$];
        int tq[$];
        int lg;
        bit prev_gv;
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, mk_beat(i, 0, 1'b1), 1'b1);
        prev_gv = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge ACLK);
            if (gv) gq.push_back(int'(grant));
            if (m_tvalid) tq.push_back(int'(m_tdata[7:0]));
            n_vec++;
            if (gv && prev_gv) begin n_err++; $display("FAIL rr_bubble: got busy twice expected gap at cycle %0d", c); end
            prev_gv = gv;
        end
        s_tvalid = '0;
        n_vec++;
        if (gq.size() < 6 || tq.size() < 5) begin
            n_err++;
            $display("FAIL rr_count: got %0d/%0d expected >=6/>=5", gq.size(), tq.size());
        end else begin
            lg = N - 1;
            for (int n = 0; n < 6; n++) begin
                lg = (lg + 1) % N;
                n_vec++;
                if (gq[n] != lg) begin n_err++; $display("FAIL rr_grant%0d: got %0d expected %0d", n, gq[n], lg); end
                if (n < 5) begin
                    n_vec++;
                    if (tq[n] != lg) begin n_err++; $display("FAIL rr_tag%0d: got %0d expected %0d", n, tq[n], lg); end
                end
            end
        end
    endtask

    task automatic test_valid_drop();
        beat_t b1[4];
        int    j, gap;
        do_reset();
        for (int k = 0; k < 4; k++) b1[k] = mk_beat(1, k, k == 3);
        set_src(1, b1[0], 1'b1);
        @(negedge ACLK);
        set_src(0, mk_beat(0, 9, 1'b1), 1'b1);
        j = 0; gap = 0;
        for (int c = 0; c < 20 && j < 4; c++) begin
            set_src(1, b1[j], gap == 0);
            #1;
            n_vec++; if (grant !== 2'd1 || gv !== 1'b1) begin n_err++; $display("FAIL vd_lock: got %0d/%b expected 1/1", grant, gv); end
            n_vec++; if (s_tready[0] !== 1'b0) begin n_err++; $display("FAIL vd_rdy0: got %b expected 0", s_tready[0]); end
            if (s_tvalid[1] && s_tready[1]) begin
                j++;
                if (j == 2) gap = 2;
            end else if (gap > 0) begin
                gap--;
            end
            @(negedge ACLK);
        end
        n_vec++; if (j != 4) begin n_err++; $display("FAIL vd_beats: got %0d expected 4", j); end
        set_src(1, b1[3], 1'b0);
        #1;
        n_vec++; if (gv !== 1'b0) begin n_err++; $display("FAIL vd_idle: got %b expected 0", gv); end
        @(negedge ACLK);
        n_vec++; if (grant !== 2'd0 || gv !== 1'b1) begin n_err++; $display("FAIL vd_next: got %0d/%b expected 0/1", grant, gv); end
        s_tvalid = '0;
    endtask

    task automatic test_stall();
        do_reset();
        gen_packets(3, 0, 1);
        for (int j = 0; j < 5; j++) srcq[3].push_back(mk_beat(3, j, j == 4));
        drop_pct  = 0;
        stall_pct = 0;
        stall_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run_traffic(40);
    endtask

    task automatic test_reset_mid();
        beat_t b2[4];
        do_reset();
        for (int j = 0; j < 4; j++) b2[j] = mk_beat(2, j, j == 3);
        set_src(2, b2[0], 1'b1);
        @(negedge ACLK);
        @(negedge ACLK);
        set_src(2, b2[1], 1'b1);
        @(negedge ACLK);
        n_vec++; if (m_beat() !== b2[1]) begin n_err++; $display("FAIL rm_beat2: got %h expected %h", m_beat(), b2[1]); end
        ARESETN  = 1'b0;
        s_tvalid = '0;
        set_src(0, mk_beat(0, 0, 1'b1), 1'b1);
        set_src(3, mk_beat(3, 0, 1'b1), 1'b1);
        @(negedge ACLK);
        n_vec++;
        if ({m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, s_tready, grant, gv} !== '0) begin
            n_err++;
            $display("FAIL rm_zero: got v=%b l=%b rdy=%b g=%0d gv=%b expected all 0", m_tvalid, m_tlast, s_tready, grant, gv);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_vec++; if (grant !== 2'd0 || gv !== 1'b1) begin n_err++; $display("FAIL rm_regrant: got %0d/%b expected 0/1", grant, gv); end
        s_tvalid = '0;
    endtask

    task automatic test_nonpow2();
        int gq[$];
        int lg;
        bit prev;
        do_reset();
        t3_tdata    = '0;
        t3_tkeep    = '0;
        t3_tuser    = '0;
        t3_tlast    = 3'b111;
        t3_m_tready = 1'b1;
        t3_tvalid   = 3'b101;
        prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            n_vec++;
            if (t3_grant > 2'd2) begin n_err++; $display("FAIL np_range: got %0d expected <3", t3_grant); end
            if (t3_gv && !prev) gq.push_back(int'(t3_grant));
            prev = t3_gv;
        end
        t3_tvalid = '0;
        n_vec++;
        if (gq.size() < 4) begin
            n_err++;
            $display("FAIL np_count: got %0d expected >=4", gq.size());
        end else begin
            lg = 2;
            for (int n = 0; n < 4; n++) begin
                for (int k = 1; k <= 3; k++) begin
                    if (((lg + k) % 3) != 1) begin lg = (lg + k) % 3; break; end
                end
                n_vec++;
                if (gq[n] != lg) begin n_err++; $display("FAIL np_grant%0d: got %0d expected %0d", n, gq[n], lg); end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int s = 0; s < N; s++) gen_packets(s, $urandom_range(0, 4), 5);
            drop_pct  = 25;
            stall_pct = 30;
            run_traffic(3000);
        end
    endtask

    initial begin
        ARESETN   = 1'b0;
        s_tdata   = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0; s_tvalid = '0;
        m_tready  = 1'b1;
        t3_tdata  = '0; t3_tkeep = '0; t3_tuser = '0; t3_tlast = '0; t3_tvalid = '0;
        t3_m_tready = 1'b1;
        drop_pct  = 0;
        stall_pct = 0;
        test_reset();
        test_single_source();
        test_round_robin();
        test_valid_drop();
        test_stall();
        test_reset_mid();
        test_nonpow2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
